// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit-instruction processor: opcodes, write-select
// encodings, sequencer states and instruction field positions.
package proc_pkg;

  localparam logic [3:0] OP_NOP       = 4'd0;
  localparam logic [3:0] OP_ADD       = 4'd1;
  localparam logic [3:0] OP_SUB       = 4'd2;
  localparam logic [3:0] OP_AND       = 4'd3;
  localparam logic [3:0] OP_OR        = 4'd4;
  localparam logic [3:0] OP_NOT       = 4'd5;
  localparam logic [3:0] OP_XOR       = 4'd6;
  localparam logic [3:0] OP_CLEAR     = 4'd7;
  localparam logic [3:0] OP_MOVE      = 4'd8;
  localparam logic [3:0] OP_LOAD      = 4'd9;
  localparam logic [3:0] OP_STORE     = 4'd10;
  localparam logic [3:0] OP_PRINT     = 4'd11;
  localparam logic [3:0] OP_PRINT7SEG = 4'd12;
  localparam logic [3:0] OP_JMP       = 4'd13;
  localparam logic [3:0] OP_ILL_A     = 4'd14;
  localparam logic [3:0] OP_ILL_B     = 4'd15;

  localparam logic [1:0] WSEL_IMM  = 2'd0;
  localparam logic [1:0] WSEL_MEM  = 2'd1;
  localparam logic [1:0] WSEL_ZERO = 2'd2;

  localparam int OP_LSB  = 12;
  localparam int REG_LSB = 8;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with reset value, parallel load and wrapping increment.
module pc_reg #(
  parameter int           W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end else if (inc) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: owns the PC and the instruction
// register, and issues one-cycle control strobes to the datapath.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            step,
  input  logic [15:0]     instr,
  output logic [PC_W-1:0] pc,
  output logic            rf_we,
  output logic [3:0]      rf_addr,
  output logic [1:0]      rf_wsel,
  output logic            dm_we,
  output logic [7:0]      dm_addr,
  output logic [3:0]      alu_op,
  output logic            acc_we,
  output logic            print_we,
  output logic            seg_we,
  output logic            busy,
  output logic            illegal
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;
  logic [3:0]  op;
  logic        last_cycle;
  logic        pc_load;
  logic        pc_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ROM data for the fetched address is valid during DECODE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir <= '0;
    end else if (state == ST_DECODE) begin
      ir <= instr;
    end
  end

  assign op      = ir[OP_LSB +: 4];
  assign alu_op  = op;
  assign rf_addr = ir[REG_LSB +: 4];
  assign dm_addr = ir[IMM_LSB +: 8];
  assign busy    = (state != ST_IDLE);

  // LOAD retires in WB, everything else in EXEC
  assign last_cycle = ((state == ST_EXEC) && (op != OP_LOAD)) || (state == ST_WB);
  assign pc_load    = last_cycle && (op == OP_JMP);
  assign pc_inc     = last_cycle && (op != OP_JMP);

  pc_reg #(
    .W         (PC_W),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .inc  (pc_inc),
    .d    (PC_W'(ir[IMM_LSB +: 8])),
    .q    (pc)
  );

  always_comb begin
    state_nxt = state;
    rf_we     = 1'b0;
    rf_wsel   = WSEL_IMM;
    dm_we     = 1'b0;
    acc_we    = 1'b0;
    print_we  = 1'b0;
    seg_we    = 1'b0;
    illegal   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (run || step) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR: acc_we = 1'b1;
          OP_MOVE: begin
            rf_we   = 1'b1;
            rf_wsel = WSEL_IMM;
          end
          OP_CLEAR: begin
            rf_we   = 1'b1;
            rf_wsel = WSEL_ZERO;
          end
          OP_STORE:          dm_we    = 1'b1;
          OP_PRINT:          print_we = 1'b1;
          OP_PRINT7SEG:      seg_we   = 1'b1;
          OP_ILL_A, OP_ILL_B: illegal = 1'b1;
          default: ;
        endcase
        if (op == OP_LOAD) begin
          state_nxt = ST_MEM;
        end else begin
          state_nxt = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_MEM: state_nxt = ST_WB;
      ST_WB: begin
        rf_we     = 1'b1;
        rf_wsel   = WSEL_MEM;
        state_nxt = run ? ST_FETCH : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
